// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: one synchronous write port, two registered read ports with valid flags.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data to a read of the same address.
module regfile_2r1w #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage lives in flops because reset must clear every entry at once.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_commit;

    logic [1:0]             rd_en_v;
    logic [1:0][ADDR_W-1:0] rd_addr_v;

    assign rd_en_v   = {rd_en_b, rd_en_a};
    assign rd_addr_v = {rd_addr_b, rd_addr_a};

    always_comb begin
        wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_commit) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [WIDTH-1:0] rd_word;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic             valid_d;
        logic             valid_q;

        always_comb begin
            rd_word = mem_q[rd_addr_v[gi]];
`ifdef WRITE_BYPASS_EN
            if (wr_commit && (wr_addr == rd_addr_v[gi])) begin
                rd_word = wr_data;
            end
`endif
            // The zero register overrides any forwarded value.
            if ((ZERO_REG != 0) && (rd_addr_v[gi] == '0)) begin
                rd_word = '0;
            end
            data_d  = data_q;
            valid_d = rd_en_v[gi];
            if (rd_en_v[gi]) begin
                data_d = rd_word;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    assign rd_data_a  = g_rd[0].data_q;
    assign rd_valid_a = g_rd[0].valid_q;
    assign rd_data_b  = g_rd[1].data_q;
    assign rd_valid_b = g_rd[1].valid_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: one instance with ZERO_REG=0 and one with ZERO_REG=1 share stimulus.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en_a = 1'b0;
    logic [3:0]  rd_addr_a = '0;
    logic        rd_en_b = 1'b0;
    logic [3:0]  rd_addr_b = '0;

    logic [15:0] rd_data_a, rd_data_b, z_data_a, z_data_b;
    logic        rd_valid_a, rd_valid_b, z_valid_a, z_valid_b;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
    );

    regfile_2r1w #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(z_data_a), .rd_valid_a(z_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(z_data_b), .rd_valid_b(z_valid_b)
    );

    typedef struct {
        logic [15:0] da, db, za, zb;
        logic        va, vb, vza, vzb;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem0 [16];
    logic [15:0] memz [16];
    logic [15:0] last_a, last_b, last_za, last_zb;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_txn   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input bit z, input logic [3:0] addr,
                                               input bit we, input logic [3:0] wa,
                                               input logic [15:0] wd);
        if (z && addr == 4'd0) return 16'h0000;
`ifdef WRITE_BYPASS_EN
        if (we && wa == addr) return wd;
`endif
        return z ? memz[addr] : mem0[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = '0;
            memz[i] = '0;
        end
        last_a = '0; last_b = '0; last_za = '0; last_zb = '0;
    endtask

    // One clock of stimulus: expectation pushed at drive time, popped after the edge.
    task automatic drive(input string tag, input bit r,
                         input bit we, input logic [3:0] wa, input logic [15:0] wd,
                         input bit ea, input logic [3:0] aa,
                         input bit eb, input logic [3:0] ab);
        exp_t e, g;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        if (r) begin
            model_clear();
            e = '{da: 16'h0, db: 16'h0, za: 16'h0, zb: 16'h0, va: 1'b0, vb: 1'b0, vza: 1'b0, vzb: 1'b0};
        end else begin
            if (ea) begin
                last_a  = model_read(0, aa, we, wa, wd);
                last_za = model_read(1, aa, we, wa, wd);
            end
            if (eb) begin
                last_b  = model_read(0, ab, we, wa, wd);
                last_zb = model_read(1, ab, we, wa, wd);
            end
            e = '{da: last_a, db: last_b, za: last_za, zb: last_zb, va: ea, vb: eb, vza: ea, vzb: eb};
            if (we) mem0[wa] = wd;
            if (we && wa != 4'd0) memz[wa] = wd;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_val({tag, ".data_a"},   {16'h0, rd_data_a}, {16'h0, g.da});
        check_val({tag, ".valid_a"},  {31'h0, rd_valid_a}, {31'h0, g.va});
        check_val({tag, ".data_b"},   {16'h0, rd_data_b}, {16'h0, g.db});
        check_val({tag, ".valid_b"},  {31'h0, rd_valid_b}, {31'h0, g.vb});
        check_val({tag, ".z_data_a"}, {16'h0, z_data_a}, {16'h0, g.za});
        check_val({tag, ".z_valid_a"}, {31'h0, z_valid_a}, {31'h0, g.vza});
        check_val({tag, ".z_data_b"}, {16'h0, z_data_b}, {16'h0, g.zb});
        check_val({tag, ".z_valid_b"}, {31'h0, z_valid_b}, {31'h0, g.vzb});
        $display("[TB] txn %0d %s rst=%0b we=%0b wa=%0d wd=%h a:%0b/%0d -> %h/%0b b:%0b/%0d -> %h/%0b za=%h zb=%h",
                 n_txn, tag, r, we, wa, wd, ea, aa, rd_data_a, rd_valid_a,
                 eb, ab, rd_data_b, rd_valid_b, z_data_a, z_data_b);
        n_txn++;
    endtask

    initial begin
        model_clear();
        // Reset state
        drive("reset0", 1, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0);
        drive("reset1", 1, 1, 4'd3, 16'h9999, 1, 4'd3, 1, 4'd3);

        // Mid-stream asynchronous reset
        drive("t1_wr", 0, 1, 4'd3, 16'hBEEF, 0, 4'd0, 0, 4'd0);
        drive("t1_rd", 0, 0, 4'd0, 16'h0, 1, 4'd3, 1, 4'd3);
        #2;
        rst = 1'b1;
        #1;
        check_val("t1_async_data_a", {16'h0, rd_data_a}, 32'h0);
        check_val("t1_async_valid_a", {31'h0, rd_valid_a}, 32'h0);
        check_val("t1_async_z_data_a", {16'h0, z_data_a}, 32'h0);
        drive("t1_rst", 1, 1, 4'd3, 16'h1111, 1, 4'd3, 1, 4'd4);
        drive("t1_after", 0, 0, 4'd0, 16'h0, 1, 4'd3, 0, 4'd0);

        // Write then read, single valid beat
        drive("t2_wr", 0, 1, 4'd5, 16'h1234, 0, 4'd0, 0, 4'd0);
        drive("t2_rd", 0, 0, 4'd0, 16'h0, 1, 4'd5, 0, 4'd0);
        drive("t2_idle", 0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0);

        // Same-cycle write/read collision
        drive("t3_wr", 0, 1, 4'd7, 16'h00AA, 0, 4'd0, 0, 4'd0);
        drive("t3_col", 0, 1, 4'd7, 16'h5555, 1, 4'd7, 1, 4'd7);
        drive("t3_rd", 0, 0, 4'd0, 16'h0, 1, 4'd7, 0, 4'd0);

        // Both ports on one address
        drive("t4_wr", 0, 1, 4'd2, 16'h0F0F, 0, 4'd0, 0, 4'd0);
        drive("t4_rd", 0, 0, 4'd0, 16'h0, 1, 4'd2, 1, 4'd2);

        // Entry 0 behaviour, entry 1 untouched
        drive("t5_wr1", 0, 1, 4'd1, 16'h0101, 0, 4'd0, 0, 4'd0);
        drive("t5_wr0", 0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 0, 4'd0);
        drive("t5_rd", 0, 0, 4'd0, 16'h0, 1, 4'd0, 1, 4'd1);
        drive("t5_col0", 0, 1, 4'd0, 16'hABCD, 1, 4'd0, 0, 4'd0);

        // Fill, then stream reads 0..15 on A, then stop
        for (int i = 0; i < 16; i++) begin
            drive("t6_fill", 0, 1, 4'(i), 16'(i * 16'h1111) ^ 16'h00A5, 0, 4'd0, 0, 4'd0);
        end
        for (int i = 0; i < 16; i++) begin
            drive("t6_stream", 0, 0, 4'd0, 16'h0, 1, 4'(i), 1, 4'($urandom_range(0, 15)));
        end
        drive("t6_stop", 0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0);
        drive("t6_hold", 0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0);

        // Random mixed traffic with frequent collisions
        for (int i = 0; i < 40; i++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(0, 15));
            drive("rand", 0, 1'($urandom_range(0, 1)), wa, 16'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? wa : 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? wa : 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
